// File: rtl/branch_predictor_if.sv
// rtl/branch_predictor_if.sv - fetch lookup, branch resolution and statistics signals
interface branch_predictor_if;
  logic [15:0] pc;
  logic [15:0] prePC;
  logic        pre_taken;
  logic        ex_valid;
  logic [15:0] ex_pc;
  logic        ex_taken;
  logic [15:0] ex_target;
  logic        ex_pred_taken;
  logic [15:0] ex_pred_target;
  logic        error;
  logic [15:0] newPC;
  logic [15:0] branch_cnt;
  logic [15:0] mispredict_cnt;

  modport master (
    output pc, ex_valid, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_target,
    input  prePC, pre_taken, error, newPC, branch_cnt, mispredict_cnt
  );

  modport slave (
    input  pc, ex_valid, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_target,
    output prePC, pre_taken, error, newPC, branch_cnt, mispredict_cnt
  );
endinterface

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit counters and mispredict recovery
module branch_predictor #(
  parameter int ENTRIES = 8,
  parameter int PC_STEP = 1
) (
  input  logic               clk,
  input  logic               rst,
  branch_predictor_if.slave  bp
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 16 - IDX_W;
  localparam logic [15:0] STEP = 16'(PC_STEP);

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [15:0]      target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];

  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic [TAG_W-1:0] rd_tag, wr_tag;
  logic             rd_hit, wr_hit;
  logic [1:0]       wr_ctr, ctr_next;

  assign rd_idx = bp.pc[IDX_W-1:0];
  assign rd_tag = bp.pc[15:IDX_W];
  assign wr_idx = bp.ex_pc[IDX_W-1:0];
  assign wr_tag = bp.ex_pc[15:IDX_W];

  // Lookup reads the array before any same-cycle update lands
  assign rd_hit        = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign bp.pre_taken  = rd_hit && ctr_q[rd_idx][1];
  assign bp.prePC      = bp.pre_taken ? target_q[rd_idx] : bp.pc + STEP;

  assign bp.error = bp.ex_valid &&
                    ((bp.ex_taken != bp.ex_pred_taken) ||
                     (bp.ex_taken && (bp.ex_target != bp.ex_pred_target)));
  assign bp.newPC = bp.ex_taken ? bp.ex_target : bp.ex_pc + STEP;

  assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
  assign wr_ctr = ctr_q[wr_idx];

  always_comb begin
    ctr_next = wr_ctr;
    if (bp.ex_taken) begin
      if (wr_ctr != 2'b11) ctr_next = wr_ctr + 2'b01;
    end else begin
      if (wr_ctr != 2'b00) ctr_next = wr_ctr - 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (bp.ex_valid) begin
      if (wr_hit) begin
        ctr_q[wr_idx] <= ctr_next;
        if (bp.ex_taken) target_q[wr_idx] <= bp.ex_target;
      end else if (bp.ex_taken) begin
        // Taken miss evicts whatever aliased into this slot
        valid_q[wr_idx]  <= 1'b1;
        tag_q[wr_idx]    <= wr_tag;
        target_q[wr_idx] <= bp.ex_target;
        ctr_q[wr_idx]    <= 2'b10;
      end
    end
  end

  logic [15:0] branch_q, mispredict_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      branch_q     <= '0;
      mispredict_q <= '0;
    end else if (bp.ex_valid) begin
      if (branch_q != 16'hFFFF) branch_q <= branch_q + 16'd1;
      if (bp.error && (mispredict_q != 16'hFFFF)) mispredict_q <= mispredict_q + 16'd1;
    end
  end

  assign bp.branch_cnt     = branch_q;
  assign bp.mispredict_cnt = mispredict_q;
endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - scoreboard bench for branch_predictor
module tb_branch_predictor;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  branch_predictor_if bif ();
  branch_predictor #(.ENTRIES(8), .PC_STEP(1)) dut (.clk(clk), .rst(rst), .bp(bif));

  typedef struct {
    string       name;
    logic [15:0] prepc;
    logic        pt;
    logic        err;
    logic [15:0] newpc;
    logic        chk_np;
    logic [15:0] bc;
    logic [15:0] mc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int vectors = 0;
  int miscompares = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] p, input logic v, input logic [15:0] xpc,
                       input logic xt, input logic [15:0] xtg, input logic xpt,
                       input logic [15:0] xptg);
    bif.pc             = p;
    bif.ex_valid       = v;
    bif.ex_pc          = xpc;
    bif.ex_taken       = xt;
    bif.ex_target      = xtg;
    bif.ex_pred_taken  = xpt;
    bif.ex_pred_target = xptg;
  endtask

  task automatic expect_v(input string n, input logic [15:0] prepc, input logic pt,
                          input logic err, input logic [15:0] np, input logic chk,
                          input logic [15:0] bc, input logic [15:0] mc);
    exp_t x;
    x.name = n; x.prepc = prepc; x.pt = pt; x.err = err;
    x.newpc = np; x.chk_np = chk; x.bc = bc; x.mc = mc;
    sb.push_back(x);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      vectors++;
      if (bif.prePC !== e.prepc || bif.pre_taken !== e.pt || bif.error !== e.err ||
          (e.chk_np && bif.newPC !== e.newpc) ||
          bif.branch_cnt !== e.bc || bif.mispredict_cnt !== e.mc) begin
        miscompares++;
        $display("FAIL %s: got prePC=%h pre_taken=%b error=%b newPC=%h bcnt=%h mcnt=%h; want prePC=%h pre_taken=%b error=%b newPC=%h(chk=%b) bcnt=%h mcnt=%h",
                 e.name, bif.prePC, bif.pre_taken, bif.error, bif.newPC,
                 bif.branch_cnt, bif.mispredict_cnt, e.prepc, e.pt, e.err,
                 e.newpc, e.chk_np, e.bc, e.mc);
      end
    end
  end

  initial begin
    drive(16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000);
    repeat (2) tick();

    tick(); rst = 1'b1;
    drive(16'h0010, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000);
    expect_v("reset_fallthrough", 16'h0011, 0, 0, 16'h0000, 0, 16'd0, 16'd0);

    tick(); drive(16'h0010, 1, 16'h0012, 1, 16'h0040, 0, 16'h0013);
    expect_v("taken_miss", 16'h0011, 0, 1, 16'h0040, 1, 16'd0, 16'd0);
    tick(); drive(16'h0012, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000);
    expect_v("alloc_hit", 16'h0040, 1, 0, 16'h0000, 0, 16'd1, 16'd1);

    tick(); drive(16'h0012, 1, 16'h0012, 0, 16'h0000, 1, 16'h0040);
    expect_v("nt_mispredict_preupdate", 16'h0040, 1, 1, 16'h0013, 1, 16'd1, 16'd1);
    tick(); drive(16'h0012, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000);
    expect_v("ctr_01_not_taken", 16'h0013, 0, 0, 16'h0000, 0, 16'd2, 16'd2);
    tick(); drive(16'h0012, 1, 16'h0012, 0, 16'h0000, 0, 16'h0013);
    expect_v("nt_correct", 16'h0013, 0, 0, 16'h0013, 1, 16'd2, 16'd2);
    tick(); drive(16'h0012, 1, 16'h0012, 1, 16'h0040, 0, 16'h0013);
    expect_v("taken_from_00", 16'h0013, 0, 1, 16'h0040, 1, 16'd3, 16'd2);
    tick(); drive(16'h0012, 1, 16'h0012, 1, 16'h0040, 0, 16'h0013);
    expect_v("taken_from_01", 16'h0013, 0, 1, 16'h0040, 1, 16'd4, 16'd3);
    tick(); drive(16'h0012, 1, 16'h0012, 1, 16'h0040, 1, 16'h0040);
    expect_v("taken_correct_10", 16'h0040, 1, 0, 16'h0040, 1, 16'd5, 16'd4);
    tick(); drive(16'h0012, 1, 16'h0012, 1, 16'h0050, 1, 16'h0040);
    expect_v("target_mismatch", 16'h0040, 1, 1, 16'h0050, 1, 16'd6, 16'd4);
    tick(); drive(16'h0012, 1, 16'h0012, 0, 16'h0000, 1, 16'h0050);
    expect_v("nt_from_11", 16'h0050, 1, 1, 16'h0013, 1, 16'd7, 16'd5);
    tick(); drive(16'h0012, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000);
    expect_v("ctr_10_after_sat", 16'h0050, 1, 0, 16'h0000, 0, 16'd8, 16'd6);

    tick(); drive(16'h001A, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000);
    expect_v("alias_miss", 16'h001B, 0, 0, 16'h0000, 0, 16'd8, 16'd6);
    tick(); drive(16'h001A, 1, 16'h001A, 1, 16'h0080, 0, 16'h001B);
    expect_v("alias_alloc", 16'h001B, 0, 1, 16'h0080, 1, 16'd8, 16'd6);
    tick(); drive(16'h0012, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000);
    expect_v("evicted_miss", 16'h0013, 0, 0, 16'h0000, 0, 16'd9, 16'd7);
    tick(); drive(16'h001A, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000);
    expect_v("alias_hit", 16'h0080, 1, 0, 16'h0000, 0, 16'd9, 16'd7);

    tick(); drive(16'h0015, 1, 16'h0015, 0, 16'h0000, 0, 16'h0099);
    expect_v("nt_miss_no_error", 16'h0016, 0, 0, 16'h0000, 0, 16'd9, 16'd7);
    tick(); drive(16'h0015, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000);
    expect_v("nt_miss_no_alloc", 16'h0016, 0, 0, 16'h0000, 0, 16'd10, 16'd7);
    tick(); drive(16'hFFFF, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000);
    expect_v("pc_wrap", 16'h0000, 0, 0, 16'h0000, 0, 16'd10, 16'd7);

    for (int i = 0; i < 65540; i++) begin
      tick(); drive(16'h0005, 1, 16'h0005, 0, 16'h0000, 0, 16'h0099);
    end
    tick(); drive(16'h001A, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000);
    expect_v("branch_cnt_saturate", 16'h0080, 1, 0, 16'h0000, 0, 16'hFFFF, 16'd7);

    tick(); drive(16'h001A, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000);
    #2 rst = 1'b0;
    expect_v("async_reset_mid_cycle", 16'h001B, 0, 0, 16'h0000, 0, 16'd0, 16'd0);
    tick(); drive(16'h001A, 1, 16'h001A, 1, 16'h0090, 0, 16'h001B);
    expect_v("error_during_reset", 16'h001B, 0, 1, 16'h0090, 1, 16'd0, 16'd0);
    tick(); rst = 1'b1;
    drive(16'h001A, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000);
    expect_v("post_reset_miss_a", 16'h001B, 0, 0, 16'h0000, 0, 16'd0, 16'd0);
    tick(); drive(16'h0012, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000);
    expect_v("post_reset_miss_b", 16'h0013, 0, 0, 16'h0000, 0, 16'd0, 16'd0);

    repeat (3) tick();
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
